// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg
// Shared widths, lane index type and drain FSM encoding for the systolic path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

   localparam int DEF_ACC_W  = 16;
   localparam int DEF_N_MACS = 4;
   localparam int LANE_W     = $clog2(DEF_N_MACS);

   typedef logic [LANE_W-1:0] lane_idx_t;

   typedef logic [0:0] drain_state_t;
   localparam drain_state_t ST_IDLE   = 1'b0;
   localparam drain_state_t ST_STREAM = 1'b1;

endpackage : systolic_pkg

`default_nettype wire

// File: rtl/tile_fifo.sv
// ============================================================================
// tile_fifo
// Synchronous first-word-fall-through FIFO holding complete result tiles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);

   // A write into a full FIFO is allowed when the head leaves on the same edge.
   assign w_rd = i_pop && !o_empty;
   assign w_wr = i_push && (!o_full || w_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule : tile_fifo

`default_nettype wire

// File: rtl/mac_array_drain.sv
// ============================================================================
// mac_array_drain
// Collects per-lane MAC results into tiles, buffers them and streams lanes out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_array_drain
   import systolic_pkg::*;
#(
   parameter int ACC_W  = DEF_ACC_W,
   parameter int N_MACS = DEF_N_MACS,
   parameter int DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_MACS*ACC_W-1:0]     acc_in,
   input  logic [N_MACS-1:0]           valid_in,
   input  logic                        flush,
   output logic [ACC_W-1:0]            out_data,
   output logic [$clog2(N_MACS)-1:0]   out_lane,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        stall,
   output logic                        err_overwrite,
   output logic                        err_overflow,
   output logic [7:0]                  drop_cnt,
   input  logic                        err_clear
);

   localparam int TW = N_MACS * ACC_W;
   localparam int LW = $clog2(N_MACS);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] c_LAST_LANE = LW'(N_MACS - 1);

   logic [N_MACS-1:0] r_mask;
   logic [TW-1:0]     r_cap;
   drain_state_t      r_state;
   logic [LW-1:0]     r_lane;
   logic              r_err_ow;
   logic              r_err_of;
   logic [7:0]        r_drop;

   logic [TW-1:0]     w_tile;
   logic [TW-1:0]     w_head;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [CW-1:0]     w_cnt_next;
   logic              w_complete;
   logic              w_ow_evt;
   logic              w_hs;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;

   // Same-cycle strobes bypass the capture registers so a tile can close
   // on the edge its final lane arrives.
   generate
      for (genvar gi = 0; gi < N_MACS; gi++) begin : g_lane
         assign w_tile[gi*ACC_W +: ACC_W] = valid_in[gi] ? acc_in[gi*ACC_W +: ACC_W]
                                                         : r_cap[gi*ACC_W +: ACC_W];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_cap[gi*ACC_W +: ACC_W] <= '0;
            end else if (valid_in[gi] && !flush) begin
               r_cap[gi*ACC_W +: ACC_W] <= acc_in[gi*ACC_W +: ACC_W];
            end
         end
      end
   endgenerate

   assign w_complete = (&(r_mask | valid_in)) && !flush;
   assign w_ow_evt   = (|(r_mask & valid_in)) && !flush;

   assign w_hs       = (r_state == ST_STREAM) && out_ready;
   assign w_pop      = w_hs && (r_lane == c_LAST_LANE) && !w_empty;
   assign w_push     = w_complete && (!w_full || w_pop);
   assign w_drop     = w_complete && !w_push;
   assign w_cnt_next = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

   tile_fifo #(
      .WIDTH (TW),
      .DEPTH (DEPTH)
   ) u_tile_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_tile),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mask <= '0;
      end else if (flush || w_complete) begin
         r_mask <= '0;
      end else begin
         r_mask <= r_mask | valid_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_lane  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cnt_next != '0) r_state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (w_hs) begin
                  if (r_lane == c_LAST_LANE) begin
                     r_lane <= '0;
                     if (w_cnt_next == '0) r_state <= ST_IDLE;
                  end else begin
                     r_lane <= r_lane + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A clear coinciding with a fresh error keeps the new event.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_ow <= 1'b0;
         r_err_of <= 1'b0;
         r_drop   <= '0;
      end else if (err_clear) begin
         r_err_ow <= w_ow_evt;
         r_err_of <= w_drop;
         r_drop   <= w_drop ? 8'd1 : 8'd0;
      end else begin
         if (w_ow_evt) r_err_ow <= 1'b1;
         if (w_drop) begin
            r_err_of <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         end
      end
   end

   assign out_valid     = (r_state == ST_STREAM);
   assign out_data      = out_valid ? w_head[r_lane*ACC_W +: ACC_W] : '0;
   assign out_lane      = r_lane;
   assign out_last      = out_valid && (r_lane == c_LAST_LANE);
   assign stall         = w_full;
   assign err_overwrite = r_err_ow;
   assign err_overflow  = r_err_of;
   assign drop_cnt      = r_drop;

endmodule : mac_array_drain

`default_nettype wire

// File: tb/tb_mac_array_drain.sv
// ============================================================================
// tb_mac_array_drain
// Scoreboard bench for mac_array_drain: expected beats queued at capture time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_array_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] acc_in;
   logic [3:0]  valid_in;
   logic        flush;
   logic [15:0] out_data;
   logic [1:0]  out_lane;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        stall;
   logic        err_overwrite;
   logic        err_overflow;
   logic [7:0]  drop_cnt;
   logic        err_clear;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  lane;
      logic        last;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   mac_array_drain #(.ACC_W(16), .N_MACS(4), .DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .acc_in        (acc_in),
      .valid_in      (valid_in),
      .flush         (flush),
      .out_data      (out_data),
      .out_lane      (out_lane),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .stall         (stall),
      .err_overwrite (err_overwrite),
      .err_overflow  (err_overflow),
      .drop_cnt      (drop_cnt),
      .err_clear     (err_clear)
   );

   function automatic void push_tile(input logic [63:0] t);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{d: t[i*16 +: 16], lane: 2'(i), last: (i == 3)});
      end
   endfunction

   task automatic drive(input logic [3:0] v, input logic [63:0] d, input logic fl);
      valid_in = v;
      acc_in   = d;
      flush    = fl;
      @(posedge clk); #1;
      valid_in = '0;
      flush    = 1'b0;
   endtask

   task automatic wait_empty(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
   endtask

   // Pops one expected beat per handshake and checks stability while stalled.
   task automatic monitor();
      beat_t got;
      beat_t held;
      beat_t exp;
      bit    hold = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            hold = 1'b0;
         end else begin
            got = '{d: out_data, lane: out_lane, last: out_last};
            if (hold) begin
               checks++;
               if (!out_valid || got !== held) begin
                  errors++;
                  $display("FAIL hold_stable: got valid=%0b d=%h lane=%0d last=%0b, required valid=1 d=%h lane=%0d last=%0b",
                           out_valid, got.d, got.lane, got.last, held.d, held.lane, held.last);
               end
            end
            if (out_valid && out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL beat_unexpected: got d=%h lane=%0d last=%0b, required no beat",
                           got.d, got.lane, got.last);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     errors++;
                     $display("FAIL beat_data: got d=%h lane=%0d last=%0b, required d=%h lane=%0d last=%0b",
                              got.d, got.lane, got.last, exp.d, exp.lane, exp.last);
                  end
               end
            end
            hold = out_valid && !out_ready;
            held = got;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_last, stall, err_overwrite, err_overflow} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got v/l/s/ow/of=%b, required 00000",
                  {out_valid, out_last, stall, err_overwrite, err_overflow});
      end
      checks++;
      if (out_data !== 16'h0 || out_lane !== 2'd0 || drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: got data=%h lane=%0d drop=%0d, required 0 0 0",
                  out_data, out_lane, drop_cnt);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got out_valid=%0b, required 0", out_valid);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      bit ok;
      logic [63:0] t;
      t = {16'h7FFF, 16'hFFFE, 16'h0002, 16'h0001};
      out_ready = 1'b1;
      push_tile(t);
      drive(4'b1111, t, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== 16'h0001) begin
         errors++;
         $display("FAIL basic_latency: got valid=%0b lane=%0d data=%h, required 1 0 0001",
                  out_valid, out_lane, out_data);
      end
      wait_empty(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_drain: got %0d beats pending, required 0", exp_q.size());
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got out_valid=%0b, required 0", out_valid);
      end
   endtask

   task automatic test_staggered();
      bit ok;
      logic [63:0] t;
      t = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      out_ready = 1'b1;
      drive(4'b0001, t, 1'b0);
      drive(4'b0110, t, 1'b0);
      drive(4'b0000, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stagger_early: got out_valid=%0b before last lane, required 0", out_valid);
      end
      push_tile(t);
      drive(4'b1000, t, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || err_overwrite !== 1'b0) begin
         errors++;
         $display("FAIL stagger_push: got valid=%0b err_ow=%0b, required 1 0", out_valid, err_overwrite);
      end
      wait_empty(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stagger_drain: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit found;
      logic [63:0] t;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         t = 64'h1000_2000_3000_4000 + 64'(k) * 64'h0001_0001_0001_0001;
         push_tile(t);
         drive(4'b1111, t, 1'b0);
      end
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL bp_stall: got stall=%0b with 4 tiles, required 1", stall);
      end
      drive(4'b1111, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0);
      checks++;
      if (err_overflow !== 1'b1 || drop_cnt !== 8'd1 || stall !== 1'b1) begin
         errors++;
         $display("FAIL bp_drop: got of=%0b drop=%0d stall=%0b, required 1 1 1",
                  err_overflow, drop_cnt, stall);
      end
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      checks++;
      if (err_overflow !== 1'b0 || drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL bp_clear: got of=%0b drop=%0d, required 0 0", err_overflow, drop_cnt);
      end
      // Push a tile on the same edge the full FIFO pops its head.
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid && out_last) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL bp_last_wait: got no last beat, required one within 20 cycles");
      end
      t = 64'h5555_6666_7777_8888;
      push_tile(t);
      drive(4'b1111, t, 1'b0);
      checks++;
      if (err_overflow !== 1'b0 || drop_cnt !== 8'd0 || stall !== 1'b1) begin
         errors++;
         $display("FAIL bp_push_pop_full: got of=%0b drop=%0d stall=%0b, required 0 0 1",
                  err_overflow, drop_cnt, stall);
      end
      wait_empty(60, ok);
      checks++;
      if (!ok || stall !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got pending=%0d stall=%0b, required 0 0", exp_q.size(), stall);
      end
   endtask

   task automatic test_overwrite_flush();
      bit ok;
      logic [63:0] t;
      out_ready = 1'b1;
      drive(4'b0100, 64'h0000_0010_0000_0000, 1'b0);
      drive(4'b0100, 64'h0000_0020_0000_0000, 1'b0);
      checks++;
      if (err_overwrite !== 1'b1) begin
         errors++;
         $display("FAIL ow_flag: got err_overwrite=%0b, required 1", err_overwrite);
      end
      t = {16'h00A3, 16'h0020, 16'h00A1, 16'h00A0};
      push_tile(t);
      drive(4'b1011, {16'h00A3, 16'hFFFF, 16'h00A1, 16'h00A0}, 1'b0);
      wait_empty(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ow_drain: got %0d beats pending, required 0", exp_q.size());
      end
      drive(4'b0111, {16'h0000, 16'h00B2, 16'h00B1, 16'h00B0}, 1'b0);
      drive(4'b1000, {16'h00BB, 48'h0}, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_tile: got out_valid=%0b after flush, required 0", out_valid);
      end
      t = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};
      push_tile(t);
      drive(4'b1111, t, 1'b0);
      wait_empty(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL flush_drain: got %0d beats pending, required 0", exp_q.size());
      end
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      checks++;
      if (err_overwrite !== 1'b0) begin
         errors++;
         $display("FAIL ow_clear: got err_overwrite=%0b, required 0", err_overwrite);
      end
   endtask

   task automatic test_handshake_random();
      int sent;
      logic [63:0] t;
      sent = 0;
      for (int cyc = 0; cyc < 8000 && !(sent == 100 && exp_q.size() == 0); cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (sent < 100 && !stall && $urandom_range(0, 2) != 0) begin
            t = {$urandom, $urandom};
            valid_in = 4'b1111;
            acc_in   = t;
            push_tile(t);
            sent++;
         end else begin
            valid_in = '0;
         end
         @(posedge clk); #1;
      end
      valid_in  = '0;
      out_ready = 1'b1;
      checks++;
      if (sent != 100 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rand_complete: got sent=%0d pending=%0d, required 100 0", sent, exp_q.size());
      end
      checks++;
      if (drop_cnt !== 8'd0 || err_overflow !== 1'b0) begin
         errors++;
         $display("FAIL rand_no_drop: got drop=%0d of=%0b, required 0 0", drop_cnt, err_overflow);
      end
   endtask

   task automatic test_reset_midstream();
      bit ok;
      bit found;
      logic [63:0] t;
      out_ready = 1'b0;
      push_tile(64'hAAAA_BBBB_CCCC_DDDD);
      drive(4'b1111, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
      push_tile(64'h1234_5678_9ABC_DEF0);
      drive(4'b1111, 64'h1234_5678_9ABC_DEF0, 1'b0);
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid && out_lane == 2'd2) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_beat2_wait: got no beat 2, required one within 20 cycles");
      end
      rst    = 1'b1;
      mon_en = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({out_valid, out_last, stall} !== 3'b0 || out_data !== 16'h0 || out_lane !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset_out: got v/l/s=%b data=%h lane=%0d, required 000 0000 0",
                  {out_valid, out_last, stall}, out_data, out_lane);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_fifo_empty: got out_valid=%0b, required 0", out_valid);
      end
      mon_en = 1'b1;
      t = 64'h0F0F_F0F0_8000_7FFF;
      push_tile(t);
      drive(4'b1111, t, 1'b0);
      wait_empty(20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL mid_after_reset: got %0d beats pending, required 0", exp_q.size());
      end
   endtask

   initial begin
      rst       = 1'b1;
      acc_in    = '0;
      valid_in  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_staggered();
      test_backpressure();
      test_overwrite_flush();
      test_handshake_random();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mac_array_drain

`default_nettype wire
